// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine feeding the MEM/WB register.
// Checks each access for legality, and for a store builds the byte-lane
// strobes and replicated write data. It runs a req/ack handshake with data
// memory, and for a load extracts the addressed byte, half or word and
// sign/zero-extends it. The pipeline is stalled until the access completes.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   valid              EX/MEM slot holds a live instruction
//   mem_read/mem_write load / store request
//   funct3             RV32I width/sign code
//   addr, wdata        byte address and store source value
//   mem_ack, mem_rdata memory completion and read word
//   mem_req, mem_we    memory request (held until ack) and write flag
//   mem_addr           word-aligned address
//   mem_wstrb          byte-lane write enables
//   mem_wdata          lane-replicated store data
//   data_o             extended load data for MEM/WB
//   done, fault        one-cycle completion pulse and its error flag
//   stall              freeze IF..EX/MEM (combinational)
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  output logic [31:0] data_o,
  output logic        done,
  output logic        fault,
  output logic        stall
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_boff;

  logic        w_start;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load;

  assign w_start = valid & (mem_read | mem_write);

  // Width codes accepted per direction, and natural alignment per width
  assign w_f3_ok = mem_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                             : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_align_ok = !((funct3[1:0] == 2'b01) && addr[0]) &&
                      !((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_legal = !(mem_read && mem_write) && w_f3_ok && w_align_ok;

  // Store lane steering: replicate the source across lanes, strobe the target ones
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // Load extraction uses the width code and byte offset latched at issue
  assign w_lane = mem_rdata >> {r_boff, 3'b000};

  always_comb begin
    w_load = w_lane;
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  // Stall is forced low during reset so the pipeline is released immediately
  assign stall = !rst && (((r_state == S_IDLE) && w_start) || (r_state == S_WAIT));

  // Access sequencer: IDLE -> WAIT -> DONE, or IDLE -> DONE for an illegal access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_funct3  <= 3'd0;
      r_boff    <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'd0;
      mem_wdata <= 32'd0;
      data_o    <= 32'd0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_legal) begin
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= mem_write ? w_wstrb : 4'd0;
              mem_wdata <= mem_write ? w_wdata : 32'd0;
              r_funct3  <= funct3;
              r_boff    <= addr[1:0];
              r_cnt     <= '0;
              r_state   <= S_WAIT;
            end else begin
              fault   <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            data_o  <= mem_we ? 32'd0 : w_load;
            fault   <= 1'b0;
            done    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            // This cycle is the last one allowed without an ack: bus fault
            mem_req <= 1'b0;
            data_o  <= 32'd0;
            fault   <= 1'b1;
            done    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          fault   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan steps followed by random
// accesses, checked against a byte-level reference model of RV32I access rules.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] data_o;
  logic        done;
  logic        fault;
  logic        stall;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_issue = 0;
  int          n_exp_issue = 0;
  logic [31:0] exp_data = 32'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .data_o(data_o), .done(done), .fault(fault),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every request to memory is counted, to catch lost or duplicated issues
  always @(posedge mem_req) n_issue++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the width code
  function automatic int unsigned ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [1:0] off);
    int unsigned nb = ref_size(f3);
    if (rd && wr) return 1'b0;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    if (rd && f3 == 3'b110) return 1'b0;
    if ((int'(off) % nb) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    int unsigned nb = ref_size(f3);
    logic [31:0] v = rd >> (8 * int'(off));
    logic [31:0] mask;
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
    int unsigned nb = ref_size(f3);
    logic [7:0] m = 8'((1 << nb) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int unsigned nb = ref_size(f3);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  // One access from IDLE through DONE; ack_at = WAIT cycle carrying the ack (0 = never)
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int ack_at, input string nm);
    bit legal;
    bit exp_f;
    legal = ref_legal(rd, wr, f3, a[1:0]);
    valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    mem_ack = 1'b0;
    #1;
    check({nm, " stall_issue"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    exp_f = 1'b1;
    if (legal) begin
      n_exp_issue++;
      for (int w = 1; w <= TMO; w++) begin
        check($sformatf("%s req_w%0d", nm, w), 32'(mem_req), 32'd1);
        check($sformatf("%s stall_w%0d", nm, w), 32'(stall), 32'd1);
        check($sformatf("%s done_w%0d", nm, w), 32'(done), 32'd0);
        check($sformatf("%s addr_w%0d", nm, w), mem_addr, {a[31:2], 2'b00});
        check($sformatf("%s we_w%0d", nm, w), 32'(mem_we), 32'(wr));
        check($sformatf("%s wstrb_w%0d", nm, w), 32'(mem_wstrb),
              wr ? 32'(ref_strb(f3, a[1:0])) : 32'd0);
        if (wr) check($sformatf("%s wdata_w%0d", nm, w), mem_wdata, ref_wdata(f3, wd));
        // Inputs wander while waiting; the access must stay latched
        mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        mem_ack = (w == ack_at);
        mem_rdata = (w == ack_at) ? rdat : $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (w == ack_at) begin
          exp_f = 1'b0;
          exp_data = wr ? 32'd0 : ref_load(f3, a[1:0], rdat);
          break;
        end
      end
      if (exp_f) exp_data = 32'd0;
    end
    check({nm, " done"}, 32'(done), 32'd1);
    check({nm, " fault"}, 32'(fault), 32'(exp_f));
    check({nm, " data_o"}, data_o, exp_data);
    check({nm, " req_done"}, 32'(mem_req), 32'd0);
    check({nm, " stall_done"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    check({nm, " done_clr"}, 32'(done), 32'd0);
    check({nm, " data_hold"}, data_o, exp_data);
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst data_o", data_o, 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // No start without valid, nor with valid but no access
    mem_read = 1'b1; #1;
    check("novalid stall", 32'(stall), 32'd0);
    mem_read = 1'b0; valid = 1'b1; #1;
    check("noop stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("noop req", 32'(mem_req), 32'd0);
    check("noop done", 32'(done), 32'd0);
    valid = 1'b0;

    do_access(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 3, "lw_100");
    do_access(1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1, "lb_103");
    do_access(1, 0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_1234, 2, "lbu_103");
    do_access(1, 0, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_1234, 1, "lhu_102");
    do_access(0, 1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'd0, 1, "sb_201");
    do_access(0, 1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'd0, 2, "sh_202");
    do_access(1, 0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 1, "lw_misal");
    do_access(1, 1, 3'b010, 32'h0000_0100, 32'd0, 32'd0, 1, "rd_wr");
    do_access(1, 0, 3'b010, 32'h0000_0104, 32'd0, 32'h1111_2222, 0, "timeout");
    check("timeout data_o", data_o, 32'd0);

    // Reset in the middle of a WAIT, then a stray ack
    do_access(1, 0, 3'b010, 32'h0000_0108, 32'd0, 32'h5555_AAAA, 1, "pre_rst");
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
    n_exp_issue++;
    @(posedge clk); #1;
    check("rst_mid req_w1", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("rst_mid req", 32'(mem_req), 32'd0);
    check("rst_mid stall", 32'(stall), 32'd0);
    check("rst_mid data_o", data_o, 32'd0);
    exp_data = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack req", 32'(mem_req), 32'd0);
    check("late_ack done", 32'(done), 32'd0);
    check("late_ack data_o", data_o, 32'd0);
    do_access(1, 0, 3'b010, 32'h0000_0310, 32'd0, 32'h0BAD_F00D, 2, "post_rst");
    do_access(1, 0, 3'b001, 32'h0000_0312, 32'd0, 32'h8001_7FFF, 1, "b2b_0");
    do_access(1, 0, 3'b000, 32'h0000_0311, 32'd0, 32'h0000_9900, 1, "b2b_1");

    // Random accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      bit rd;
      bit wr;
      rd = 1'($urandom);
      wr = !rd;
      if ($urandom_range(0, 9) == 0) begin rd = 1'b1; wr = 1'b1; end
      do_access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(1, TMO + 1)), $sformatf("rnd%0d", i));
    end

    @(posedge clk); #1;
    check("issue count", 32'(n_issue), 32'(n_exp_issue));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
